// File: rtl/controle_multiciclo_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, ALU ops, mux selects and FSM states.
package pkg_controle;

  localparam int W_SEL = 2;

  localparam logic [2:0] OPC_R      = 3'b000;
  localparam logic [2:0] OPC_LW     = 3'b001;
  localparam logic [2:0] OPC_SW     = 3'b010;
  localparam logic [2:0] OPC_BEQ    = 3'b011;
  localparam logic [2:0] OPC_J      = 3'b100;
  localparam logic [2:0] OPC_ADDI   = 3'b101;
  localparam logic [2:0] OPC_ILEGAL = 3'b110;
  localparam logic [2:0] OPC_HALT   = 3'b111;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_FUNCT = 2'b10;
  localparam logic [1:0] OP_INV   = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_UM   = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_DESL = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_EXEC_R  = 4'd2,
    ST_R_WB    = 4'd3,
    ST_EXEC_I  = 4'd4,
    ST_I_WB    = 4'd5,
    ST_MEM_END = 4'd6,
    ST_MEM_LER = 4'd7,
    ST_MEM_WB  = 4'd8,
    ST_MEM_ESC = 4'd9,
    ST_BRANCH  = 4'd10,
    ST_JUMP    = 4'd11,
    ST_HALT    = 4'd12,
    ST_ERRO    = 4'd13
  } estado_t;

endpackage

// File: rtl/controle_multiciclo_if.sv
// Control/datapath bundle: master is the control unit, slave is the datapath side.
interface controle_multiciclo_if
  import pkg_controle::*;
#(
  parameter int LARGURA_OP = 3
);
  logic [LARGURA_OP-1:0] opcode;
  logic                  mem_pronta;
  logic                  alu_erro;
  logic                  pcWrite;
  logic                  pcWriteCond;
  logic                  iorD;
  logic                  memRead;
  logic                  memWrite;
  logic                  irWrite;
  logic                  memToReg;
  logic                  regWrite;
  logic                  regDst;
  logic                  aluSrcA;
  logic [W_SEL-1:0]      aluSrcB;
  logic [W_SEL-1:0]      opAlu;
  logic [W_SEL-1:0]      pcSource;
  logic                  parado;
  logic                  erro;

  modport master (
    input  opcode, mem_pronta, alu_erro,
    output pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
           regWrite, regDst, aluSrcA, aluSrcB, opAlu, pcSource, parado, erro
  );

  modport slave (
    output opcode, mem_pronta, alu_erro,
    input  pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
           regWrite, regDst, aluSrcA, aluSrcB, opAlu, pcSource, parado, erro
  );
endinterface

// File: rtl/controle_multiciclo_contador.sv
// Memory-wait counter: counts enabled cycles, clears on request, flags the last allowed wait cycle.
module contador_espera #(
  parameter int MAX_ESPERA = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_limite
);
  localparam int W = (MAX_ESPERA > 1) ? $clog2(MAX_ESPERA + 1) : 1;
  localparam logic [W-1:0] LIM = (MAX_ESPERA > 0) ? W'(MAX_ESPERA - 1) : '0;

  logic [W-1:0] r_cnt;

  // Saturates so an unbounded wait (MAX_ESPERA = 0) never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  // High during the wait cycle that would bring the count up to MAX_ESPERA.
  assign o_limite = (MAX_ESPERA != 0) && (r_cnt == LIM);

endmodule

// File: rtl/controle_multiciclo.sv
// Multi-cycle main control FSM: fetch/decode/execute/memory/writeback with memory-wait timeout and traps.
module controle_multiciclo
  import pkg_controle::*;
#(
  parameter int LARGURA_OP = 3,
  parameter int MAX_ESPERA = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  controle_multiciclo_if.master bus
);
  estado_t               r_estado;
  estado_t               w_prox;
  logic [LARGURA_OP-1:0] r_op;
  logic                  w_limite;
  logic                  w_espera;
  logic                  w_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= ST_FETCH;
      r_op     <= '0;
    end else begin
      r_estado <= w_prox;
      if (r_estado == ST_DECODE) r_op <= bus.opcode;
    end
  end

  assign w_espera = ((r_estado == ST_FETCH) || (r_estado == ST_MEM_LER) ||
                     (r_estado == ST_MEM_ESC)) && !bus.mem_pronta;
  assign w_clr    = (w_prox != r_estado);

  contador_espera #(.MAX_ESPERA(MAX_ESPERA)) u_contador (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_clr),
    .i_en     (w_espera),
    .o_limite (w_limite)
  );

  always_comb begin
    w_prox          = r_estado;
    bus.pcWrite     = 1'b0;
    bus.pcWriteCond = 1'b0;
    bus.iorD        = 1'b0;
    bus.memRead     = 1'b0;
    bus.memWrite    = 1'b0;
    bus.irWrite     = 1'b0;
    bus.memToReg    = 1'b0;
    bus.regWrite    = 1'b0;
    bus.regDst      = 1'b0;
    bus.aluSrcA     = 1'b0;
    bus.aluSrcB     = SRCB_REG;
    bus.opAlu       = OP_ADD;
    bus.pcSource    = PCSRC_ALU;
    bus.parado      = 1'b0;
    bus.erro        = 1'b0;

    case (r_estado)
      ST_FETCH: begin
        bus.memRead = 1'b1;
        bus.aluSrcB = SRCB_UM;
        if (bus.mem_pronta) begin
          bus.irWrite = 1'b1;
          bus.pcWrite = 1'b1;
          w_prox      = ST_DECODE;
        end else if (w_limite) begin
          w_prox = ST_ERRO;
        end
      end
      ST_DECODE: begin
        bus.aluSrcB = SRCB_DESL;
        case (bus.opcode)
          LARGURA_OP'(OPC_R):    w_prox = ST_EXEC_R;
          LARGURA_OP'(OPC_LW):   w_prox = ST_MEM_END;
          LARGURA_OP'(OPC_SW):   w_prox = ST_MEM_END;
          LARGURA_OP'(OPC_BEQ):  w_prox = ST_BRANCH;
          LARGURA_OP'(OPC_J):    w_prox = ST_JUMP;
          LARGURA_OP'(OPC_ADDI): w_prox = ST_EXEC_I;
          LARGURA_OP'(OPC_HALT): w_prox = ST_HALT;
          default:               w_prox = ST_ERRO;
        endcase
      end
      ST_EXEC_R: begin
        bus.aluSrcA = 1'b1;
        bus.opAlu   = OP_FUNCT;
        w_prox      = bus.alu_erro ? ST_ERRO : ST_R_WB;
      end
      ST_R_WB: begin
        bus.regDst   = 1'b1;
        bus.regWrite = 1'b1;
        w_prox       = ST_FETCH;
      end
      ST_EXEC_I, ST_MEM_END: begin
        bus.aluSrcA = 1'b1;
        bus.aluSrcB = SRCB_IMM;
        if (r_estado == ST_EXEC_I)                 w_prox = ST_I_WB;
        else if (r_op == LARGURA_OP'(OPC_SW))      w_prox = ST_MEM_ESC;
        else                                       w_prox = ST_MEM_LER;
      end
      ST_I_WB: begin
        bus.regWrite = 1'b1;
        w_prox       = ST_FETCH;
      end
      ST_MEM_LER, ST_MEM_ESC: begin
        bus.iorD     = 1'b1;
        bus.memRead  = (r_estado == ST_MEM_LER);
        bus.memWrite = (r_estado == ST_MEM_ESC);
        if (bus.mem_pronta) w_prox = (r_estado == ST_MEM_LER) ? ST_MEM_WB : ST_FETCH;
        else if (w_limite)  w_prox = ST_ERRO;
      end
      ST_MEM_WB: begin
        bus.memToReg = 1'b1;
        bus.regWrite = 1'b1;
        w_prox       = ST_FETCH;
      end
      ST_BRANCH: begin
        bus.aluSrcA     = 1'b1;
        bus.opAlu       = OP_SUB;
        bus.pcWriteCond = 1'b1;
        bus.pcSource    = PCSRC_ALUOUT;
        w_prox          = ST_FETCH;
      end
      ST_JUMP: begin
        bus.pcWrite  = 1'b1;
        bus.pcSource = PCSRC_JUMP;
        w_prox       = ST_FETCH;
      end
      ST_HALT: bus.parado = 1'b1;
      ST_ERRO: begin
        bus.parado = 1'b1;
        bus.erro   = 1'b1;
      end
      default: w_prox = ST_ERRO;
    endcase

    // Outputs go quiet the instant reset asserts, before the clock sees it.
    if (!rst_n) begin
      bus.pcWrite     = 1'b0;
      bus.pcWriteCond = 1'b0;
      bus.iorD        = 1'b0;
      bus.memRead     = 1'b0;
      bus.memWrite    = 1'b0;
      bus.irWrite     = 1'b0;
      bus.memToReg    = 1'b0;
      bus.regWrite    = 1'b0;
      bus.regDst      = 1'b0;
      bus.aluSrcA     = 1'b0;
      bus.aluSrcB     = SRCB_REG;
      bus.opAlu       = OP_ADD;
      bus.pcSource    = PCSRC_ALU;
      bus.parado      = 1'b0;
      bus.erro        = 1'b0;
    end
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: per-instruction expected output sequences built from the instruction rules.
module tb_controle_multiciclo;
  localparam int MAXW = 15;

  // Field order: pcWrite pcWriteCond iorD memRead memWrite irWrite memToReg regWrite regDst aluSrcA aluSrcB opAlu pcSource parado erro
  localparam logic [17:0] ZERO   = 18'b0;
  localparam logic [17:0] F_WAIT = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] F_GO   = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] DEC    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] EXR    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0};
  localparam logic [17:0] RWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] EXI    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] IWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] MLER   = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] MWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] MESC   = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] BR     = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0,1'b0};
  localparam logic [17:0] JMP    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0,1'b0};
  localparam logic [17:0] HLT    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
  localparam logic [17:0] ERR    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b1};

  typedef struct {
    logic        mp;
    logic        ae;
    logic [2:0]  op;
    logic [17:0] exp;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        mp;
  logic        ae;
  logic [2:0]  op;
  logic [17:0] got;
  logic [2:0]  cur_op;
  ent_t        q[$];
  string       qn[$];
  int          checks;
  int          errors;
  int          rw_cnt;
  int          m2r_cnt;
  int          iord_cnt;
  int          base;
  bit          term;

  controle_multiciclo_if #(.LARGURA_OP(3)) bus ();

  assign bus.opcode     = op;
  assign bus.mem_pronta = mp;
  assign bus.alu_erro   = ae;
  assign got = {bus.pcWrite, bus.pcWriteCond, bus.iorD, bus.memRead, bus.memWrite,
                bus.irWrite, bus.memToReg, bus.regWrite, bus.regDst, bus.aluSrcA,
                bus.aluSrcB, bus.opAlu, bus.pcSource, bus.parado, bus.erro};

  controle_multiciclo #(.LARGURA_OP(3), .MAX_ESPERA(MAXW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [17:0] g, input logic [17:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got %b expected %b", nm, g, e);
    end
  endtask

  task automatic chkint(input string nm, input int g, input int e);
    checks++;
    if (g != e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, g, e);
    end
  endtask

  task automatic push(input logic m, input logic a, input logic [17:0] e, input string nm);
    ent_t t;
    t.mp = m; t.ae = a; t.op = cur_op; t.exp = e;
    q.push_back(t);
    qn.push_back(nm);
  endtask

  // One instruction as a cycle list: fw/mw are memory wait cycles, any wait run reaching MAXW traps.
  task automatic instr(input logic [2:0] opc, input int fw, input int mw,
                       input logic ae_exec, input logic noise, output bit trm);
    logic [17:0] mv;
    cur_op = opc;
    trm = 1'b0;
    for (int k = 1; k <= fw; k++) begin
      push(1'b0, noise, F_WAIT, "fetch_wait");
      if (k == MAXW) begin trm = 1'b1; return; end
    end
    push(1'b1, noise, F_GO, "fetch");
    push(noise, noise, DEC, "decode");
    case (opc)
      3'b000: begin
        push(noise, ae_exec, EXR, "exec_r");
        if (ae_exec) trm = 1'b1;
        else push(noise, noise, RWB, "r_wb");
      end
      3'b001, 3'b010: begin
        mv = (opc == 3'b001) ? MLER : MESC;
        push(noise, noise, EXI, "mem_end");
        for (int k = 1; k <= mw; k++) begin
          push(1'b0, noise, mv, "mem_wait");
          if (k == MAXW) begin trm = 1'b1; return; end
        end
        push(1'b1, noise, mv, "mem_done");
        if (opc == 3'b001) push(noise, noise, MWB, "mem_wb");
      end
      3'b011: push(noise, noise, BR, "branch");
      3'b100: push(noise, noise, JMP, "jump");
      3'b101: begin
        push(noise, noise, EXI, "exec_i");
        push(noise, noise, IWB, "i_wb");
      end
      default: trm = 1'b1;
    endcase
  endtask

  task automatic tail(input int n, input logic [17:0] e, input string nm);
    for (int i = 0; i < n; i++) push(1'b1, 1'b1, e, nm);
  endtask

  task automatic run();
    rw_cnt = 0; m2r_cnt = 0; iord_cnt = 0;
    foreach (q[i]) begin
      @(posedge clk); #1;
      rst_n = 1'b1;
      mp = q[i].mp;
      ae = q[i].ae;
      op = q[i].op;
      @(negedge clk);
      chk(qn[i], got, q[i].exp);
      rw_cnt   += int'(got[10]);
      m2r_cnt  += int'(got[11]);
      iord_cnt += int'(got[15]);
    end
    q.delete();
    qn.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 chk("reset_async", got, ZERO);
    @(negedge clk);
    chk("reset_hold", got, ZERO);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; mp = 1'b0; ae = 1'b0; op = 3'b000;

    // Instruction mix with alu_erro/mem_pronta noise outside the states that use them.
    do_reset();
    base = q.size(); instr(3'b000, 0, 0, 1'b0, 1'b1, term);
    chkint("len_rtype", q.size() - base, 4);
    chkint("model_rtype_opalu", int'(q[base + 2].exp[5:4]), 2);
    base = q.size(); instr(3'b011, 0, 0, 1'b0, 1'b1, term);
    chkint("len_beq", q.size() - base, 3);
    base = q.size(); instr(3'b100, 1, 0, 1'b0, 1'b1, term);
    chkint("len_j_1wait", q.size() - base, 4);
    base = q.size(); instr(3'b101, 0, 0, 1'b0, 1'b1, term);
    chkint("len_addi", q.size() - base, 4);
    base = q.size(); instr(3'b010, 0, 1, 1'b0, 1'b1, term);
    chkint("len_sw_1wait", q.size() - base, 5);
    instr(3'b111, 0, 0, 1'b0, 1'b1, term);
    tail(5, HLT, "halt");
    run();

    // lw with two memory wait cycles.
    do_reset();
    instr(3'b001, 0, 2, 1'b0, 1'b0, term);
    chkint("len_lw_2wait", q.size(), 7);
    cur_op = 3'b000;
    push(1'b0, 1'b0, F_WAIT, "back_to_fetch");
    run();
    chkint("lw_regwrite_once", rw_cnt, 1);
    chkint("lw_memtoreg_once", m2r_cnt, 1);
    chkint("lw_iord_cycles", iord_cnt, 3);

    // Illegal opcode trap.
    do_reset();
    instr(3'b110, 0, 0, 1'b0, 1'b0, term);
    tail(20, ERR, "erro_opcode");
    run();

    // Illegal funct trap in EXEC_R.
    do_reset();
    instr(3'b000, 0, 0, 1'b1, 1'b0, term);
    tail(3, ERR, "erro_funct");
    run();
    chkint("alu_erro_no_regwrite", rw_cnt, 0);

    // Fetch timeout: 15th wait cycle traps.
    do_reset();
    instr(3'b000, 40, 0, 1'b0, 1'b0, term);
    chkint("len_timeout_waits", q.size(), MAXW);
    tail(3, ERR, "erro_timeout");
    run();

    // mem_pronta on the 15th cycle wins over the timeout.
    do_reset();
    instr(3'b000, MAXW - 1, 0, 1'b0, 1'b0, term);
    chkint("len_edge_rtype", q.size(), MAXW - 1 + 4);
    push(1'b0, 1'b0, F_WAIT, "back_to_fetch");
    run();

    // Memory-read timeout.
    do_reset();
    instr(3'b001, 0, 40, 1'b0, 1'b0, term);
    tail(2, ERR, "erro_mem_timeout");
    run();

    // Reset mid-instruction during R writeback.
    do_reset();
    instr(3'b000, 0, 0, 1'b0, 1'b0, term);
    void'(q.pop_back());
    void'(qn.pop_back());
    run();
    @(posedge clk); #1;
    @(negedge clk);
    chk("r_wb_before_reset", got, RWB);
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_instr", got, ZERO);
    @(posedge clk); #1;
    rst_n = 1'b1; mp = 1'b0;
    @(negedge clk);
    chk("fetch_after_reset", got, F_WAIT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
